// File: rtl/branch_resolve_unit_if.sv
// Branch resolve bus: groups the request, ALU compare and response signals of
// branch_resolve_unit into one bundle.
//   master : decode/issue + ALU + PC-select side (drives requests, GES, rsp_ready)
//   slave  : branch_resolve_unit (drives req_ready, ALU operands, responses)
// Parameter XLEN sets data/PC width and must match the unit it connects to.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_imm;
    logic [XLEN-1:0] alu_arg1;
    logic [XLEN-1:0] alu_arg2;
    logic [3:0]      alu_ctrl;
    logic [2:0]      alu_ges;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_taken;
    logic [XLEN-1:0] rsp_target;
    logic            rsp_illegal;
    logic            rsp_ges_err;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
        output alu_ges, rsp_ready,
        input  req_ready, alu_arg1, alu_arg2, alu_ctrl,
        input  rsp_valid, rsp_taken, rsp_target, rsp_illegal, rsp_ges_err
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
        input  alu_ges, rsp_ready,
        output req_ready, alu_arg1, alu_arg2, alu_ctrl,
        output rsp_valid, rsp_taken, rsp_target, rsp_illegal, rsp_ges_err
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: takes one branch request from decode, drives the ALU
// with the compare operands and an unsigned (1000) / signed (1001) compare
// code for ALU_LAT cycles, samples the GES flags and returns taken/next-PC.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    branch_resolve_unit_if.slave (request, ALU compare, response)
// Parameters: ALU_LAT (>=1) cycles from ALU drive to GES sample; XLEN width.
// Optional macro BRU_GES_CHECK_EN: flag non-one-hot GES as rsp_ges_err and
// force not-taken; when undefined rsp_ges_err is tied 0.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// ISSUE | ALU operands/code driven, down-counter running, GES sampled at end
// RESP  | first cycle builds the response, then rsp_valid held until accepted
module branch_resolve_unit #(
    parameter int ALU_LAT = 1,
    parameter int XLEN    = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [2:0]        ges_q, ges_d;
    logic              illegal_q, illegal_d;
    logic              req_ready_q, req_ready_d;
    logic [XLEN-1:0]   alu_arg1_q, alu_arg1_d;
    logic [XLEN-1:0]   alu_arg2_q, alu_arg2_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_taken_q, rsp_taken_d;
    logic [XLEN-1:0]   rsp_target_q, rsp_target_d;
    logic              rsp_illegal_q, rsp_illegal_d;
    logic              rsp_ges_err_q, rsp_ges_err_d;

    logic              ges_eq, ges_lt, ges_gt;
    logic              taken_raw, taken_w, ges_err_w;
    logic [XLEN-1:0]   target_w;

    // Resolution from the captured request and the sampled GES flags.
    always_comb begin
        ges_eq = (ges_q == 3'b010);
        ges_lt = (ges_q == 3'b001);
        ges_gt = (ges_q == 3'b100);
        case (funct3_q)
            3'b000:         taken_raw = ges_eq;
            3'b001:         taken_raw = !ges_eq;
            3'b100, 3'b110: taken_raw = ges_lt;
            3'b101, 3'b111: taken_raw = ges_gt || ges_eq;
            default:        taken_raw = 1'b0;
        endcase
`ifdef BRU_GES_CHECK_EN
        ges_err_w = !illegal_q && !(ges_eq || ges_lt || ges_gt);
`else
        ges_err_w = 1'b0;
`endif
        taken_w  = taken_raw && !illegal_q && !ges_err_w;
        target_w = taken_w ? (pc_q + imm_q) : (pc_q + XLEN'(4));
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        funct3_d      = funct3_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        ges_d         = ges_q;
        illegal_d     = illegal_q;
        alu_arg1_d    = alu_arg1_q;
        alu_arg2_d    = alu_arg2_q;
        alu_ctrl_d    = alu_ctrl_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_taken_d   = rsp_taken_q;
        rsp_target_d  = rsp_target_q;
        rsp_illegal_d = rsp_illegal_q;
        rsp_ges_err_d = rsp_ges_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    funct3_d = bus.req_funct3;
                    pc_d     = bus.req_pc;
                    imm_d    = bus.req_imm;
                    if (bus.req_funct3[2:1] == 2'b01) begin
                        illegal_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        illegal_d  = 1'b0;
                        state_d    = ISSUE;
                        cnt_d      = CNT_W'(ALU_LAT - 1);
                        alu_arg1_d = bus.req_rs1;
                        alu_arg2_d = bus.req_rs2;
                        // BLTU/BGEU (11x) compare unsigned, the rest signed
                        alu_ctrl_d = (bus.req_funct3[2:1] == 2'b11) ? 4'b1000 : 4'b1001;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    ges_d      = bus.alu_ges;
                    state_d    = RESP;
                    alu_arg1_d = '0;
                    alu_arg2_d = '0;
                    alu_ctrl_d = 4'b0000;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d   = 1'b1;
                    rsp_taken_d   = taken_w;
                    rsp_target_d  = target_w;
                    rsp_illegal_d = illegal_q;
                    rsp_ges_err_d = ges_err_w;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_taken_d   = 1'b0;
                    rsp_target_d  = '0;
                    rsp_illegal_d = 1'b0;
                    rsp_ges_err_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so that req_ready reads 0 throughout reset.
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            funct3_q      <= 3'b000;
            pc_q          <= '0;
            imm_q         <= '0;
            ges_q         <= 3'b000;
            illegal_q     <= 1'b0;
            req_ready_q   <= 1'b0;
            alu_arg1_q    <= '0;
            alu_arg2_q    <= '0;
            alu_ctrl_q    <= 4'b0000;
            rsp_valid_q   <= 1'b0;
            rsp_taken_q   <= 1'b0;
            rsp_target_q  <= '0;
            rsp_illegal_q <= 1'b0;
            rsp_ges_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            funct3_q      <= funct3_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            ges_q         <= ges_d;
            illegal_q     <= illegal_d;
            req_ready_q   <= req_ready_d;
            alu_arg1_q    <= alu_arg1_d;
            alu_arg2_q    <= alu_arg2_d;
            alu_ctrl_q    <= alu_ctrl_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_taken_q   <= rsp_taken_d;
            rsp_target_q  <= rsp_target_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_ges_err_q <= rsp_ges_err_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.alu_arg1    = alu_arg1_q;
    assign bus.alu_arg2    = alu_arg2_q;
    assign bus.alu_ctrl    = alu_ctrl_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_taken   = rsp_taken_q;
    assign bus.rsp_target  = rsp_target_q;
    assign bus.rsp_illegal = rsp_illegal_q;
    assign bus.rsp_ges_err = rsp_ges_err_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (ALU_LAT=1, XLEN=32).
module tb_branch_resolve_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

    branch_resolve_unit #(.ALU_LAT(1), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"},   bus.req_ready,   0);
        check({tag, " alu_arg1"},    bus.alu_arg1,    0);
        check({tag, " alu_arg2"},    bus.alu_arg2,    0);
        check({tag, " alu_ctrl"},    bus.alu_ctrl,    0);
        check({tag, " rsp_valid"},   bus.rsp_valid,   0);
        check({tag, " rsp_taken"},   bus.rsp_taken,   0);
        check({tag, " rsp_target"},  bus.rsp_target,  0);
        check({tag, " rsp_illegal"}, bus.rsp_illegal, 0);
        check({tag, " rsp_ges_err"}, bus.rsp_ges_err, 0);
    endtask

    // One complete branch: accept, ALU phase (legal only), response, optional
    // stall with rsp_ready low, handshake.
    task automatic run_branch(input string name, input logic [2:0] f3,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [2:0] ges, input logic [3:0] e_ctrl,
                              input logic e_taken, input logic [31:0] e_target,
                              input logic e_ill, input logic e_err, input int stall);
        check({name, " ready_idle"}, bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_pc     = pc;
        bus.req_imm    = imm;
        bus.alu_ges    = 3'b000;
        step();
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'b011;
        bus.req_rs1    = 32'hDEAD_BEEF;
        bus.req_rs2    = 32'h1234_5678;
        bus.req_pc     = 32'hAAAA_0000;
        bus.req_imm    = 32'h0000_5555;
        if (!e_ill) begin
            check({name, " alu_ctrl"}, bus.alu_ctrl, e_ctrl);
            check({name, " alu_arg1"}, bus.alu_arg1, rs1);
            check({name, " alu_arg2"}, bus.alu_arg2, rs2);
            check({name, " early_valid"}, bus.rsp_valid, 0);
            check({name, " ready_busy"}, bus.req_ready, 0);
            bus.alu_ges = ges;
            step();
            bus.alu_ges = 3'b000;
            check({name, " alu_ctrl_clr"}, bus.alu_ctrl, 0);
            check({name, " alu_arg1_clr"}, bus.alu_arg1, 0);
            check({name, " early_valid2"}, bus.rsp_valid, 0);
        end else begin
            check({name, " alu_ctrl_idle"}, bus.alu_ctrl, 0);
            check({name, " alu_arg1_idle"}, bus.alu_arg1, 0);
            check({name, " early_valid"}, bus.rsp_valid, 0);
        end
        step();
        check({name, " rsp_valid"},   bus.rsp_valid,   1);
        check({name, " rsp_taken"},   bus.rsp_taken,   e_taken);
        check({name, " rsp_target"},  bus.rsp_target,  e_target);
        check({name, " rsp_illegal"}, bus.rsp_illegal, e_ill);
        check({name, " rsp_ges_err"}, bus.rsp_ges_err, e_err);
        check({name, " ready_resp"},  bus.req_ready,   0);
        // A new request offered during RESP must be ignored.
        bus.req_valid  = (stall > 0);
        bus.req_funct3 = 3'b000;
        for (int i = 0; i < stall; i++) begin
            step();
            check({name, " stall_valid"},  bus.rsp_valid,  1);
            check({name, " stall_taken"},  bus.rsp_taken,  e_taken);
            check({name, " stall_target"}, bus.rsp_target, e_target);
            check({name, " stall_ready"},  bus.req_ready,  0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check({name, " valid_drop"},  bus.rsp_valid, 0);
        check({name, " ready_again"}, bus.req_ready, 1);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_pc     = '0;
        bus.req_imm    = '0;
        bus.alu_ges    = 3'b000;
        bus.rsp_ready  = 1'b0;
        #1;
        check_all_zero("reset");
        step();
        step();
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        step();
        check("post_reset ready", bus.req_ready, 1);
        check("post_reset valid", bus.rsp_valid, 0);

        //          name     f3      rs1           rs2  pc            imm           ges     ctrl     tk  target        ill err stall
        run_branch("beq",   3'b000, 32'h5,        32'h5, 32'h100,      32'h20,       3'b010, 4'b1001, 1, 32'h120,       0, 0, 0);
        run_branch("bltu",  3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300,     32'h40,       3'b100, 4'b1000, 0, 32'h304,       0, 0, 0);
        run_branch("blt",   3'b100, 32'hFFFF_FFFF, 32'h1, 32'h300,     32'h40,       3'b001, 4'b1001, 1, 32'h340,       0, 0, 0);
        run_branch("bge_w", 3'b101, 32'h7,        32'h7, 32'hFFFF_FFF0, 32'h20,      3'b010, 4'b1001, 1, 32'h10,        0, 0, 0);
        run_branch("bgeu",  3'b111, 32'h1,        32'h9, 32'h400,      32'h10,       3'b001, 4'b1000, 0, 32'h404,       0, 0, 0);
        run_branch("bne_eq",3'b001, 32'h3,        32'h3, 32'h500,      32'hFFFF_FFF0, 3'b010, 4'b1001, 0, 32'h504,      0, 0, 0);
        run_branch("bne_ne",3'b001, 32'h3,        32'h4, 32'h500,      32'hFFFF_FFF0, 3'b001, 4'b1001, 1, 32'h4F0,      0, 0, 0);
        run_branch("ill010",3'b010, 32'h1,        32'h2, 32'h200,      32'h80,       3'b010, 4'b0000, 0, 32'h204,       1, 0, 0);
        run_branch("ill011",3'b011, 32'h1,        32'h2, 32'h210,      32'h80,       3'b010, 4'b0000, 0, 32'h214,       1, 0, 0);
`ifdef BRU_GES_CHECK_EN
        run_branch("bne_bad",3'b001, 32'h1,       32'h2, 32'h600,      32'h8,        3'b011, 4'b1001, 0, 32'h604,       0, 1, 0);
`else
        run_branch("bne_bad",3'b001, 32'h1,       32'h2, 32'h600,      32'h8,        3'b011, 4'b1001, 1, 32'h608,       0, 0, 0);
`endif
        run_branch("beq_bp",3'b000, 32'h9,        32'h8, 32'h700,      32'h100,      3'b100, 4'b1001, 0, 32'h704,       0, 0, 5);

        // Reset asserted mid-ISSUE: everything clears immediately, no response.
        bus.req_valid  = 1'b1;
        bus.req_funct3 = 3'b100;
        bus.req_rs1    = 32'h1;
        bus.req_rs2    = 32'h2;
        bus.req_pc     = 32'h800;
        bus.req_imm    = 32'h40;
        step();
        bus.req_valid  = 1'b0;
        bus.alu_ges    = 3'b001;
        check("abort in_issue ctrl", bus.alu_ctrl, 4'b1001);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort async");
        step();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort no_rsp", bus.rsp_valid, 0);
        end
        check("abort ready", bus.req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
